button_conditioner: RTL

- Upstream front-end for the card-board cursor/selection logic of the memory game.
- Converts the two raw active-low push buttons (MOVE, SELECT) into clean pulses: `move` and `select`.
- Each pulse is registered and exactly one clk cycle wide, so the downstream cursor counter and turn logic see one event per physical press.
- Work per button: two-flop synchroniser, counter-based debounce FSM, press-edge pulse, and SELECT-over-MOVE arbitration.

---
 rtl/button_pkg.sv | 13 +
 rtl/button_conditioner_if.sv | 21 ++
 rtl/button_conditioner_debounce_fsm.sv | 86 ++++++++
 rtl/button_conditioner.sv | 96 +++++++++
 4 files changed

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and defaults for the button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw key inputs and conditioned pulse/level outputs.
interface button_conditioner_if;

  logic key_move_n;
  logic key_select_n;
  logic move;
  logic select;
  logic move_held;
  logic select_held;

  modport master (
    output key_move_n, key_select_n,
    input  move, select, move_held, select_held
  );

  modport slave (
    input  key_move_n, key_select_n,
    output move, select, move_held, select_held
  );

endinterface

// File: rtl/button_conditioner_debounce_fsm.sv
// rtl/button_conditioner_debounce_fsm.sv - synchroniser, debounce FSM and counter for one button.
module debounce_fsm
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic fire,
  output logic held,
  output logic in_pressed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             p;
  btn_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= 2'b11;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], key_n};
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  assign p       = ~sync[1];
  assign cnt_inc = cnt + 1'b1;

  // The entry sample counts as the first stable cycle, so the wait states
  // leave when the incremented count reaches the last value.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    fire       = 1'b0;
    unique case (state)
      IDLE: begin
        if (p) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_inc == CNT_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
          fire       = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      PRESSED: begin
        if (!p) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (p) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_inc == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
    endcase
  end

  assign held       = (state == PRESSED) || (state == RELEASE_WAIT);
  assign in_pressed = (state == PRESSED);

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - MOVE/SELECT debounce, one-cycle pulses and SELECT-priority arbitration.
// Optional MOVE auto-repeat: BUTTON_CONDITIONER_MOVE_AUTOREPEAT_EN.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES),
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY must be at least 2 and REPEAT_PERIOD at least 1");
  end

  logic move_fire, move_held, move_in_pressed;
  logic select_fire, select_held, select_pressed_unused;
  logic repeat_fire;
  logic move_q, select_q, pending;
  logic move_req;

  debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_move (
    .clk(clk), .rst(rst), .key_n(bus.key_move_n),
    .fire(move_fire), .held(move_held), .in_pressed(move_in_pressed)
  );

  debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_select (
    .clk(clk), .rst(rst), .key_n(bus.key_select_n),
    .fire(select_fire), .held(select_held), .in_pressed(select_pressed_unused)
  );

`ifdef BUTTON_CONDITIONER_MOVE_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX);
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             repeating;

  assign repeat_fire = move_in_pressed &&
                       (rep_cnt == (repeating ? REP_PERIOD_LAST : REP_DELAY_LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt   <= '0;
      repeating <= 1'b0;
    end else if (!move_in_pressed) begin
      rep_cnt   <= '0;
      repeating <= 1'b0;
    end else if (repeat_fire) begin
      rep_cnt   <= '0;
      repeating <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  logic move_pressed_unused;
  assign repeat_fire         = 1'b0;
  assign move_pressed_unused = move_in_pressed;
`endif

  // A move that loses to select is parked in pending and emitted next cycle.
  assign move_req = move_fire | repeat_fire | pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      move_q   <= 1'b0;
      select_q <= 1'b0;
      pending  <= 1'b0;
    end else begin
      select_q <= select_fire;
      if (select_fire) begin
        move_q  <= 1'b0;
        pending <= move_req;
      end else begin
        move_q  <= move_req;
        pending <= 1'b0;
      end
    end
  end

  assign bus.move        = move_q;
  assign bus.select      = select_q;
  assign bus.move_held   = move_held;
  assign bus.select_held = select_held;

endmodule
